range_arbiter: RTL
==================

# range_arbiter

Round-robin arbiter and sequencer sharing one `RangeFinder` between two sample-stream requesters. A granted requester streams a programmed number of samples. The block turns the stream into the finder's go/data/finish protocol, captures the finder's range/error result, and returns it to the winner with a one-cycle done pulse. It sits between the client logic and the single `RangeFinder` instance in the top level.

## Interface
- `WIDTH`, 8: sample and range width.
- `LEN_W`, 4: width of the per-request sample count.
- `TIMEOUT`, 15: stall limit in cycles; used only when `RANGE_ARB_TIMEOUT_EN` is defined.

- `clock`  in  1  the only clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  2  level request, one bit per requester.
- `len0`, `len1`  in  LEN_W each  sample count, sampled at grant.
- `data0`, `data1`  in  WIDTH each  sample data.
- `valid0`, `valid1`  in  1 each  sample valid.
- `ready`  out  2  sample accept; a sample is accepted when valid and ready are both high.
- `grant`  out  2  one-hot owner, high from grant through DONE.
- `done`  out  2  one-cycle completion pulse to the owner.
- `result`  out  WIDTH  captured range, held until the next done.
- `result_err`  out  1  captured error, held until the next done.
- `busy`  out  1  high in any state other than IDLE.
- `rf_data`  out  WIDTH  to finder `data_in`.
- `rf_go`  out  1  to finder `go`.
- `rf_finish`  out  1  to finder `finish`.
- `rf_range`  in  WIDTH  from finder `range`.
- `rf_error`  in  1  from finder `error`.

## Operation
- Reset value of all outputs is 0. State goes to IDLE and the priority pointer to requester 0.
- States: IDLE, RUN, DRAIN, CAPTURE, DONE.
- **IDLE**
  - If any `req` bit is high, grant the requester at the pointer if it is requesting; otherwise grant the other one.
  - Latch that requester's `len`. Flip the pointer to the other requester.
  - If the latched len < 2, go to DONE with `result`=0 and `result_err`=1. The finder is never started.
  - Otherwise go to RUN and clear the sample counter.
- **RUN**
  - `ready[owner]`=1; the other ready bit is 0.
  - Each accepted sample is registered onto `rf_data`, visible the next cycle.
  - The 1st accepted sample drives `rf_go`=1 for that cycle.
  - The len-th accepted sample drives `rf_finish`=1 and moves the state to DRAIN.
  - In a bubble cycle (no acceptance), `rf_data` repeats the last sample and `rf_go`/`rf_finish` are 0. Repeating a sample leaves the range unchanged.
- **DRAIN**: `rf_finish` is visible to the finder during this cycle.
- **CAPTURE**: register `rf_range` into `result` and `rf_error` into `result_err`.
- **DONE**: `done[owner]`=1 for one cycle, then drop `grant` and return to IDLE.
- Dropping `req` mid-run is ignored; the run completes.
- A requester that still holds `req` after its done re-enters arbitration with lower priority.
- Counter width is LEN_W; len = 2^LEN_W−1 is the maximum run length, and the counter cannot wrap.
- Reset mid-operation aborts immediately: outputs go to 0 and no done is issued. The finder shares the reset, so it is reset too.

## Timing
- From `req` high in IDLE (cycle 0): `grant` and `ready` are high from cycle 1.
- Last sample accepted in cycle A:
  - `rf_finish`=1 in A+1 (DRAIN).
  - Finder result is sampled in A+2 (CAPTURE).
  - `done`, `result` and `result_err` are valid in A+3.
  - IDLE in A+4.
- len < 2: `done` is high in cycle 2 after the grant edge.
- `rf_go` and `rf_finish` are never high in the same cycle.

## Configuration
- `RANGE_ARB_TIMEOUT_EN` defined:
  - In RUN, `TIMEOUT` consecutive cycles without an accepted sample abort the run.
  - If `rf_go` was already issued, drive `rf_finish` once with the repeated last sample. Follow the DRAIN/CAPTURE/DONE path, but force `result_err`=1.
  - If no sample was accepted yet, go straight to DONE with `result`=0 and `result_err`=1.
- Not defined: RUN waits indefinitely for samples and the stall counter is absent.

## Test plan
- req0, len0=4, samples 10, 3, 25, 7 back-to-back:
  - `rf_go` with 10, `rf_finish` with 7.
  - `done[0]` at A+3 with `result`=22, `result_err`=0.
- `req`=2'b11 right after reset, both held:
  - Grants in order 0, 1, 0, 1.
  - `ready` is never high for both requesters at once.
- req1, len1=3, samples 5, then a 3-cycle bubble, then 9, 1:
  - `rf_data` holds 5 through the bubble.
  - `result`=8.
- len0=1:
  - `done[0]` 2 cycles after grant, `result`=0, `result_err`=1.
  - `rf_go` stays 0.
- With `RANGE_ARB_TIMEOUT_EN`, `TIMEOUT`=8, len0=4, only 2 samples sent:
  - `rf_finish` pulses after 8 idle cycles.
  - `done[0]` with `result_err`=1.
  - Without the macro, no done for at least 100 cycles.
- Assert `reset` mid-RUN:
  - All outputs go to 0 asynchronously.
  - The next req1, len1=2 run (samples 4, 9) gives `result`=5.

Source files
------------

// File: rtl/range_arbiter_if.sv
// Client-side streams plus the shared RangeFinder hookup for range_arbiter.
// master = clients/finder side, slave = the arbiter.
interface range_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0, len1;
  logic [WIDTH-1:0] data0, data1;
  logic             valid0, valid1;
  logic [1:0]       ready, grant, done;
  logic [WIDTH-1:0] result;
  logic             result_err;
  logic             busy;
  logic [WIDTH-1:0] rf_data;
  logic             rf_go, rf_finish;
  logic [WIDTH-1:0] rf_range;
  logic             rf_error;

  modport master (
    output req, len0, len1, data0, data1, valid0, valid1, rf_range, rf_error,
    input  ready, grant, done, result, result_err, busy, rf_data, rf_go, rf_finish
  );

  modport slave (
    input  req, len0, len1, data0, data1, valid0, valid1, rf_range, rf_error,
    output ready, grant, done, result, result_err, busy, rf_data, rf_go, rf_finish
  );
endinterface

// File: rtl/range_arbiter.sv
// Round-robin sharing of one RangeFinder between two sample streams.
// Optional stall abort is enabled by defining RANGE_ARB_TIMEOUT_EN.
module range_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           reset,
  range_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       r_state;
  logic             r_ptr, r_owner, r_zero, r_ferr;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [WIDTH-1:0] r_rf_data, r_result;
  logic             r_rf_go, r_rf_finish, r_result_err;

  logic             w_win, w_valid, w_accept, w_stall_hit;
  logic [LEN_W-1:0] w_len_sel;
  logic [WIDTH-1:0] w_data;
  logic [1:0]       w_owner_oh;

  // Pointer requester wins if it is asking, otherwise the other one.
  assign w_win      = bus.req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_len_sel  = w_win ? bus.len1 : bus.len0;
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;
  assign w_valid    = r_owner ? bus.valid1 : bus.valid0;
  assign w_data     = r_owner ? bus.data1 : bus.data0;
  assign w_accept   = (r_state == S_RUN) && w_valid;

  assign bus.grant      = (r_state != S_IDLE)    ? w_owner_oh : 2'b00;
  assign bus.ready      = (r_state == S_RUN)     ? w_owner_oh : 2'b00;
  assign bus.done       = (r_state == S_DONE)    ? w_owner_oh : 2'b00;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.rf_data    = r_rf_data;
  assign bus.rf_go      = r_rf_go;
  assign bus.rf_finish  = r_rf_finish;
  assign bus.result     = r_result;
  assign bus.result_err = r_result_err;

`ifdef RANGE_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] r_stall;

  assign w_stall_hit = (r_state == S_RUN) && !w_accept &&
                       (r_stall == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              r_stall <= '0;
    else if (r_state != S_RUN || w_accept)  r_stall <= '0;
    else                                    r_stall <= r_stall + 1'b1;
  end
`else
  // Stall abort compiled out: RUN waits for samples forever.
  assign w_stall_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_zero       <= 1'b0;
      r_ferr       <= 1'b0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_rf_data    <= '0;
      r_rf_go      <= 1'b0;
      r_rf_finish  <= 1'b0;
      r_result     <= '0;
      r_result_err <= 1'b0;
    end else begin
      r_rf_go     <= 1'b0;
      r_rf_finish <= 1'b0;
      case (r_state)
        S_IDLE: if (|bus.req) begin
          r_owner <= w_win;
          r_ptr   <= ~w_win;
          r_len   <= w_len_sel;
          r_cnt   <= '0;
          r_ferr  <= 1'b0;
          // Too short to form a range: report an error without starting the finder.
          if (w_len_sel < LEN_W'(2)) begin
            r_zero  <= 1'b1;
            r_state <= S_CAPTURE;
          end else begin
            r_zero  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: if (w_accept) begin
          r_rf_data <= w_data;
          r_cnt     <= r_cnt + 1'b1;
          r_rf_go   <= (r_cnt == '0);
          if (r_cnt == r_len - 1'b1) begin
            r_rf_finish <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end else if (w_stall_hit) begin
          // Finder already started: close it on the repeated sample, flag error.
          if (r_cnt != '0) begin
            r_ferr      <= 1'b1;
            r_rf_finish <= 1'b1;
            r_state     <= S_DRAIN;
          end else begin
            r_result     <= '0;
            r_result_err <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DRAIN: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_result     <= r_zero ? '0 : bus.rf_range;
          r_result_err <= r_zero | r_ferr | bus.rf_error;
          r_state      <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
